// File: rtl/dragon_game_pkg.sv
// Shared game constants, the shot slot record and the fixed-point to pixel helper.
package dragon_game_pkg;

  localparam int FIXED_SHIFT = 6;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  typedef struct packed {
    logic               active;
    logic signed [31:0] x_fp;
    logic signed [31:0] y_fp;
  } shot_t;

  function automatic logic signed [10:0] to_px(input logic signed [31:0] fp);
    return 11'(fp >>> FIXED_SHIFT);
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Strict axis-aligned overlap test between box A (A_W x A_H) and box B (B_W x B_H).
module rect_overlap #(
  parameter int A_W = 4,
  parameter int A_H = 8,
  parameter int B_W = 64,
  parameter int B_H = 48
) (
  input  logic signed [10:0] a_x_i,
  input  logic signed [10:0] a_y_i,
  input  logic signed [10:0] b_x_i,
  input  logic signed [10:0] b_y_i,
  output logic               overlap_o
);

  int ax, ay, bx, by;

  always_comb begin
    ax = int'(a_x_i);
    ay = int'(a_y_i);
    bx = int'(b_x_i);
    by = int'(b_y_i);
    overlap_o = (ax < bx + B_W) && (bx < ax + A_W) &&
                (ay < by + B_H) && (by < ay + A_H);
  end

endmodule

// File: rtl/shot_dragon_hit_ctrl.sv
// Player shot slots: spawn on fire, move up once per frame, detect dragon hits
// and report one-clock collision pulses plus a saturating hit counter.
module shot_dragon_hit_ctrl
  import dragon_game_pkg::*;
#(
  parameter int NUM_SHOTS       = 3,
  parameter int SHOT_SPEED_Y    = -256,
  parameter int SHOT_W          = 4,
  parameter int SHOT_H          = 8,
  parameter int PLAYER_W        = 32,
  parameter int DRAGON_W        = 64,
  parameter int DRAGON_H        = 48,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic                        pause,
  input  logic                        fireReq,
  input  logic signed [10:0]          playerTopLeftX,
  input  logic signed [10:0]          playerTopLeftY,
  input  logic signed [10:0]          dragonTopLeftX,
  input  logic signed [10:0]          dragonTopLeftY,
  output logic [NUM_SHOTS-1:0]        shotDragonCollision,
  output logic [NUM_SHOTS-1:0]        shotActive,
  output logic [NUM_SHOTS-1:0][10:0]  shotTopLeftX,
  output logic [NUM_SHOTS-1:0][10:0]  shotTopLeftY,
  output logic [7:0]                  hitCount
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int IW = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;

  shot_t              shots_q [NUM_SHOTS];
  shot_t              shots_d [NUM_SHOTS];
  logic               fire_prev_q;
  logic               fire_pend_q, fire_pend_d;
  logic [CW-1:0]      cool_q, cool_d;
  logic [NUM_SHOTS-1:0] hit_q, hit_now, ovl;
  logic [7:0]         cnt_q, cnt_d;
  logic signed [10:0] sx_px [NUM_SHOTS];
  logic signed [10:0] sy_px [NUM_SHOTS];
  logic               dragon_live, frame, fire_rise, free_found;
  logic [IW-1:0]      free_idx;
  logic signed [31:0] y_next;
  logic [8:0]         hit_pop, cnt_sum;

  // A dragon parked off the right edge of the screen can never be hit.
  assign dragon_live = int'(dragonTopLeftX) < SCREEN_W;

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    assign sx_px[g] = to_px(shots_q[g].x_fp);
    assign sy_px[g] = to_px(shots_q[g].y_fp);

    rect_overlap #(
      .A_W(SHOT_W),
      .A_H(SHOT_H),
      .B_W(DRAGON_W),
      .B_H(DRAGON_H)
    ) u_ovl (
      .a_x_i    (sx_px[g]),
      .a_y_i    (sy_px[g]),
      .b_x_i    (dragonTopLeftX),
      .b_y_i    (dragonTopLeftY),
      .overlap_o(ovl[g])
    );

    assign hit_now[g]      = shots_q[g].active && ovl[g] && dragon_live;
    assign shotActive[g]   = shots_q[g].active;
    assign shotTopLeftX[g] = sx_px[g];
    assign shotTopLeftY[g] = sy_px[g];
  end

  assign shotDragonCollision = hit_q;
  assign hitCount            = cnt_q;

  always_comb begin
    shots_d     = shots_q;
    cool_d      = cool_q;
    frame       = startOfFrame && !pause;
    fire_rise   = fireReq && !fire_prev_q;
    fire_pend_d = fire_pend_q | fire_rise;
    free_found  = 1'b0;
    free_idx    = '0;
    y_next      = '0;

    // Free slots are judged on the pre-edge state, so a slot vacated by a hit
    // or a retire this edge is not handed out until the next frame.
    for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
      if (!shots_q[i].active && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end

    for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
      y_next = shots_q[i].y_fp + SHOT_SPEED_Y;
      if (hit_now[i]) begin
        shots_d[i].active = 1'b0;
      end else if (frame && shots_q[i].active) begin
        shots_d[i].y_fp = y_next;
        if ((y_next >>> FIXED_SHIFT) < -SHOT_H) shots_d[i].active = 1'b0;
      end
    end

    if (frame) begin
      if (cool_q != '0) begin
        cool_d = cool_q - 1'b1;
      end else if (fire_pend_q && free_found) begin
        shots_d[free_idx].active = 1'b1;
        shots_d[free_idx].x_fp   = (int'(playerTopLeftX) + PLAYER_W / 2 - SHOT_W / 2) <<< FIXED_SHIFT;
        shots_d[free_idx].y_fp   = (int'(playerTopLeftY) - SHOT_H) <<< FIXED_SHIFT;
        cool_d                   = CW'(COOLDOWN_FRAMES);
        fire_pend_d              = fire_rise;
      end
    end
  end

  always_comb begin
    hit_pop = '0;
    for (int unsigned i = 0; i < NUM_SHOTS; i++) hit_pop = hit_pop + 9'(hit_now[i]);
    cnt_sum = {1'b0, cnt_q} + hit_pop;
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SHOTS; i++) shots_q[i] <= '0;
      fire_prev_q <= 1'b0;
      fire_pend_q <= 1'b0;
      cool_q      <= '0;
      hit_q       <= '0;
      cnt_q       <= '0;
    end else begin
      shots_q     <= shots_d;
      fire_prev_q <= fireReq;
      fire_pend_q <= fire_pend_d;
      cool_q      <= cool_d;
      hit_q       <= hit_now;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shot_dragon_hit_ctrl.sv
// Scoreboard bench for shot_dragon_hit_ctrl: a pixel-level game model predicts every
// cycle's outputs; a monitor compares them and matches collision pulses against a queue.
module tb_shot_dragon_hit_ctrl;

  localparam int N = 3;

  logic clk = 1'b0, reset = 1'b0, sof = 1'b0, pause = 1'b0, fire = 1'b0;
  logic signed [10:0] px = '0, py = '0, dx = '0, dy = '0;
  logic [N-1:0]       coll, act;
  logic [N-1:0][10:0] sx, sy;
  logic [7:0]         hcnt;

  shot_dragon_hit_ctrl #(.NUM_SHOTS(N)) dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (sof),
    .pause              (pause),
    .fireReq            (fire),
    .playerTopLeftX     (px),
    .playerTopLeftY     (py),
    .dragonTopLeftX     (dx),
    .dragonTopLeftY     (dy),
    .shotDragonCollision(coll),
    .shotActive         (act),
    .shotTopLeftX       (sx),
    .shotTopLeftY       (sy),
    .hitCount           (hcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]       act;
    logic [N-1:0]       hit;
    logic [N-1:0][10:0] x;
    logic [N-1:0][10:0] y;
    logic [7:0]         cnt;
  } snap_t;

  snap_t        snapq[$];
  logic [N-1:0] hitq[$];
  snap_t        em;
  logic [N-1:0] eh;
  int checks = 0, errors = 0;

  // Reference game state in whole pixels.
  bit m_act[N];
  int m_x[N], m_y[N];
  int m_cool = 0, m_cnt = 0;
  bit m_pend = 1'b0, m_prev = 1'b0;

  function automatic void chk(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endfunction

  task automatic tick();
    logic [N-1:0] hits;
    snap_t e;
    int fs, ddx, ddy, nhit;
    hits = '0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_cool = 0; m_cnt = 0; m_pend = 0; m_prev = 0;
    end else begin
      ddx = int'(dx);
      ddy = int'(dy);
      for (int i = 0; i < N; i++)
        hits[i] = m_act[i] && (ddx < 640) && (m_x[i] < ddx + 64) && (ddx < m_x[i] + 4)
                  && (m_y[i] < ddy + 48) && (ddy < m_y[i] + 8);
      fs = -1;
      for (int i = 0; i < N; i++) if (!m_act[i] && fs < 0) fs = i;
      for (int i = 0; i < N; i++) begin
        if (hits[i]) m_act[i] = 0;
        else if (sof && !pause && m_act[i]) begin
          m_y[i] = m_y[i] - 4;
          if (m_y[i] < -8) m_act[i] = 0;
        end
      end
      if (sof && !pause) begin
        if (m_cool > 0) m_cool--;
        else if (m_pend && fs >= 0) begin
          m_act[fs] = 1;
          m_x[fs]   = int'(px) + 14;
          m_y[fs]   = int'(py) - 8;
          m_cool    = 8;
          m_pend    = 0;
        end
      end
      if (fire && !m_prev) m_pend = 1;
      m_prev = fire;
      nhit  = $countones(hits);
      m_cnt = (m_cnt + nhit > 255) ? 255 : m_cnt + nhit;
      if (hits != '0) hitq.push_back(hits);
    end
    for (int i = 0; i < N; i++) begin
      e.act[i] = m_act[i];
      e.x[i]   = 11'(m_x[i]);
      e.y[i]   = 11'(m_y[i]);
    end
    e.hit = hits;
    e.cnt = 8'(m_cnt);
    snapq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (snapq.size() > 0) begin
      em = snapq.pop_front();
      chk("active", int'(act), int'(em.act));
      chk("collision", int'(coll), int'(em.hit));
      chk("hitCount", int'(hcnt), int'(em.cnt));
      for (int i = 0; i < N; i++) if (em.act[i]) begin
        chk("shotX", int'(sx[i]), int'(em.x[i]));
        chk("shotY", int'(sy[i]), int'(em.y[i]));
      end
    end
    if (coll != '0) begin
      if (hitq.size() == 0) begin
        checks++; errors++;
        $display("FAIL hit_pulse actual=%b required=none at %0t", coll, $time);
      end else begin
        eh = hitq.pop_front();
        chk("hit_pulse", int'(coll), int'(eh));
      end
    end
  end

  task automatic frame(int gap);
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic press();
    fire = 1'b1; tick(); fire = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; repeat (3) tick(); reset = 1'b0; tick();
  endtask

  initial begin
    #2;
    do_reset();

    // Reset mid-flight with two shots in the air.
    px = 11'sd100; py = 11'sd400; dx = 11'sd700; dy = '0;
    press(); frame(1); press();
    repeat (10) frame(1);
    chk("two_active", int'(act), 3);
    reset = 1'b1; repeat (3) tick();
    chk("rst_active", int'(act), 0);
    chk("rst_x0", int'(sx[0]), 0);
    chk("rst_count", int'(hcnt), 0);
    reset = 1'b0; repeat (3) tick();
    chk("no_pulse_after_rst", int'(coll), 0);

    // Spawn position and movement.
    do_reset();
    px = 11'sd300; py = 11'sd400;
    press(); frame(1);
    chk("spawn_active", int'(act[0]), 1);
    chk("spawn_x", int'(sx[0]), 314);
    chk("spawn_y", int'(sy[0]), 392);
    repeat (3) frame(1);
    chk("move_y", int'(sy[0]), 380);

    // Cooldown, pending fire and spawn into a retired slot.
    do_reset();
    press(); frame(1); press();
    repeat (12) frame(1);
    press(); repeat (12) frame(1);
    chk("three_active", int'(act), 7);
    press(); repeat (110) frame(1);

    // Hit on the dragon, then parked dragon in the shot path.
    do_reset();
    px = 11'sd296; py = 11'sd158; dx = 11'sd300; dy = 11'sd100;
    press(); repeat (3) frame(1);
    chk("hit_count_one", int'(hcnt), 1);
    chk("hit_retired", int'(act[0]), 0);
    dx = 11'sd680;
    press(); repeat (30) frame(1);
    chk("parked_no_hit", int'(hcnt), 1);

    // Hit and frame on the same edge with a fire pending.
    do_reset();
    dx = 11'sd700;
    press(); repeat (10) frame(1);
    press();
    dx = 11'sd290; dy = 11'(m_y[0] - 10);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("same_edge_pulse", int'(coll[0]), 1);
    chk("same_edge_slot0", int'(act[0]), 0);
    chk("same_edge_slot1", int'(act[1]), 1);
    repeat (4) tick();

    // Pause freezes movement and cooldown.
    do_reset();
    dx = 11'sd700; px = 11'sd300; py = 11'sd400;
    press(); frame(1); press();
    pause = 1'b1; repeat (5) frame(1); pause = 1'b0;
    chk("pause_frozen_y", int'(sy[0]), 392);
    repeat (12) frame(1);

    // Saturating hit counter: dragon sits on the spawn point.
    do_reset();
    px = 11'sd200; py = 11'sd300; dx = 11'sd200; dy = 11'sd260;
    repeat (2700) begin fire = ~fire; frame(1); end
    chk("hit_saturate", int'(hcnt), 255);
    fire = 1'b0;

    // Randomized play.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      sof   = ($urandom_range(0, 2) == 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      if ($urandom_range(0, 59) == 0) begin
        px = 11'($urandom_range(0, 600));
        py = 11'($urandom_range(20, 470));
      end
      if ($urandom_range(0, 39) == 0) begin
        dx = 11'(int'($urandom_range(0, 760)) - 60);
        dy = 11'($urandom_range(0, 400));
      end
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0; sof = 1'b0; pause = 1'b0;
    repeat (3) tick();

    chk("hit_queue_drained", hitq.size(), 0);
    chk("snap_queue_drained", snapq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
